// File: rtl/dw_lp_cntr_updn_ctrl.sv
// Up/down sweep controller for an external loadable up/down counter.
// Loads lo, counts up to hi and back down to lo for num_pass passes, then pulses done.
module dw_lp_cntr_updn_ctrl #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  lo_val,
  input  logic [WIDTH-1:0]  hi_val,
  input  logic [PASS_W-1:0] num_pass,
  input  logic [WIDTH-1:0]  count,
  input  logic              term_count_n,
  output logic              enable,
  output logic              up_dn,
  output logic              ld_n,
  output logic [WIDTH-1:0]  ld_count,
  output logic [WIDTH-1:0]  term_val,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PASS_W-1:0] pass_cnt,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]  ONE_W = WIDTH'(1);
  localparam logic [PASS_W-1:0] ONE_P = PASS_W'(1);

  state_t              state, state_n;
  logic [WIDTH-1:0]    lo_q, lo_n, hi_q, hi_n;
  logic [PASS_W-1:0]   npass_q, npass_n;
  logic                enable_n, up_dn_n, ld_n_n, busy_n, done_n, err_n;
  logic [WIDTH-1:0]    ld_count_n, term_val_n;
  logic [PASS_W-1:0]   pass_cnt_n, pass_inc;
  logic                sync_bad;
  logic [WIDTH-1:0]    hi_m1, lo_p1;

  assign state_dbg = state;
  assign hi_m1     = hi_q - ONE_W;
  assign lo_p1     = lo_q + ONE_W;
  assign pass_inc  = pass_cnt + ONE_P;
  // Terminal flag asserted while the counter is not at the value we told it to stop at.
  assign sync_bad  = !term_count_n && (count != term_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      npass_q  <= '0;
      enable   <= 1'b0;
      up_dn    <= 1'b1;
      ld_n     <= 1'b1;
      ld_count <= '0;
      term_val <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pass_cnt <= '0;
    end else begin
      state    <= state_n;
      lo_q     <= lo_n;
      hi_q     <= hi_n;
      npass_q  <= npass_n;
      enable   <= enable_n;
      up_dn    <= up_dn_n;
      ld_n     <= ld_n_n;
      ld_count <= ld_count_n;
      term_val <= term_val_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      pass_cnt <= pass_cnt_n;
    end
  end

  // Outputs are decoded for the state being entered, so they are valid the cycle it is occupied.
  always_comb begin
    state_n    = state;
    lo_n       = lo_q;
    hi_n       = hi_q;
    npass_n    = npass_q;
    enable_n   = 1'b0;
    up_dn_n    = up_dn;
    ld_n_n     = 1'b1;
    ld_count_n = ld_count;
    term_val_n = term_val;
    done_n     = 1'b0;
    err_n      = 1'b0;
    pass_cnt_n = pass_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          if ((lo_val < hi_val) && (num_pass != '0)) begin
            state_n    = S_LOAD;
            lo_n       = lo_val;
            hi_n       = hi_val;
            npass_n    = num_pass;
            pass_cnt_n = '0;
            ld_n_n     = 1'b0;
            ld_count_n = lo_val;
            up_dn_n    = 1'b1;
            term_val_n = hi_val;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_n = S_IDLE;
        end else begin
          state_n    = S_UP;
          enable_n   = 1'b1;
          up_dn_n    = 1'b1;
          term_val_n = hi_q;
        end
      end
      S_UP: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (sync_bad) begin
          state_n = S_IDLE;
          err_n   = 1'b1;
        end else if (count == hi_m1) begin
          // Turn around one step early so the counter lands on hi on this edge.
          state_n    = S_DOWN;
          enable_n   = 1'b1;
          up_dn_n    = 1'b0;
          term_val_n = lo_q;
        end else begin
          enable_n = 1'b1;
        end
      end
      S_DOWN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (sync_bad) begin
          state_n = S_IDLE;
          err_n   = 1'b1;
        end else if (count == lo_p1) begin
          pass_cnt_n = pass_inc;
          if (pass_inc == npass_q) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n    = S_UP;
            enable_n   = 1'b1;
            up_dn_n    = 1'b1;
            term_val_n = hi_q;
          end
        end else begin
          enable_n = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign busy_n = (state_n == S_LOAD) || (state_n == S_UP) || (state_n == S_DOWN);

endmodule

// File: doc/dw_lp_cntr_updn_ctrl.md
DW_LP_CNTR_UPDN_CTRL -- requirements
Module: dw_lp_cntr_updn_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: width of count, ld_count, term_val, lo_val and hi_val.
REQ-002 Parameter PASS_W, default 4: width of num_pass and pass_cnt.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a sweep; sampled in IDLE only.
REQ-006 abort  input  1  terminates any active sweep.
REQ-007 lo_val, hi_val  input  WIDTH  sweep endpoints (unsigned); captured on accepted start.
REQ-008 num_pass  input  PASS_W  number of up+down passes; captured on accepted start.
REQ-009 count  input  WIDTH  current value from the controlled up/down counter.
REQ-010 term_count_n  input  1  counter terminal-count flag, active-low, low when count==term_val.
REQ-011 enable, up_dn, ld_n  output  1  counter controls (up_dn=1 counts up; ld_n=0 loads).
REQ-012 ld_count, term_val  output  WIDTH  counter load value and terminal value.
REQ-013 busy  output  1  high in LOAD, UP and DOWN.
REQ-014 done, err  output  1  one-cycle status pulses.
REQ-015 pass_cnt  output  PASS_W  number of completed passes in the current sweep.

Function
REQ-016 All outputs SHALL be registered; FSM states are IDLE, LOAD, UP, DOWN and DONE.
REQ-017 IDLE: start=1 with lo_val<hi_val and num_pass!=0 -> LOAD, capturing lo, hi and npass; pass_cnt<=0.
REQ-018 IDLE: start=1 with an invalid config -> remain IDLE, err=1 for one cycle.
REQ-019 LOAD (1 cycle): ld_n=0, ld_count=lo, enable=0, up_dn=1, term_val=hi; then -> UP.
REQ-020 UP: ld_n=1, enable=1, up_dn=1, term_val=hi; when count==hi-1 -> DOWN (up_dn=0, term_val=lo), so the counter reaches hi on the same edge.
REQ-021 DOWN: enable=1, up_dn=0, term_val=lo; when count==lo+1 -> pass_cnt+1.
REQ-022 At that point: if the new pass_cnt==npass -> DONE, else -> UP (up_dn=1, term_val=hi).
REQ-023 DONE (1 cycle): enable=0, done=1; then -> IDLE. The counter rests at lo.
REQ-024 Sync check in UP/DOWN: term_count_n=0 while count!=term_val -> IDLE, enable=0, err=1 for one cycle, no done.
REQ-025 abort=1 in LOAD/UP/DOWN -> IDLE next edge: enable=0, ld_n=1, no done, no err; abort has priority over every other transition.
REQ-026 start while not in IDLE SHALL be ignored; term_count_n SHALL be ignored in IDLE, LOAD and DONE.
REQ-027 hi==lo+1 SHALL be supported: lookahead fires on the first UP cycle, giving a one-cycle dwell per direction.
REQ-028 pass_cnt SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-029 When rst_n=0, asynchronously: state=IDLE, enable=0, up_dn=1, ld_n=1, ld_count=0, term_val=0, busy=0, done=0, err=0, pass_cnt=0.
REQ-030 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse; operation resumes only on a new start after deassertion.

Verification
REQ-031 Basic sweep: lo=1, hi=3, npass=1, start at edge0.
- Required: LOAD at edge1 (ld_n=0, ld_count=1).
- Required counter sequence: 1,2,3,2,1.
- Required: up_dn falls on the edge where count reaches 3; done pulses on the edge where count reaches 1; pass_cnt=1.
REQ-032 Multi-pass: lo=0, hi=15, npass=3.
- Required: count oscillates 0..15..0 three times with no overshoot past 0 or 15.
- Required: pass_cnt steps 1, 2, 3, then exactly one done.
REQ-033 Invalid config: (lo=5, hi=5) and (lo=2, hi=6, npass=0).
- Required: err pulses once, busy stays 0, enable stays 0.
REQ-034 Minimum span: lo=7, hi=8, npass=2.
- Required count sequence: 7,8,7,8,7, then done.
REQ-035 Abort and reset mid-sweep:
- abort during DOWN -> IDLE next edge, enable=0, no done.
- rst_n low during UP -> immediate reset values per REQ-029.
- A later start runs a full sweep correctly.
REQ-036 Sync error: force term_count_n=0 while count!=term_val in UP.
- Required: err=1 for one cycle, return to IDLE, enable=0.
